// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift unit.
//   - Operation encoding for the op port (SLL / SRL / SRA / ROTR).
//   - Controller state encoding (IDLE / SHIFT / DONE).
package shift_pkg;

    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_ROTR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
// Ports:
//   i_op   - operation select (shift_pkg SHIFT_* encoding)
//   i_data - current working value
//   o_data - value after one 1-bit step of the selected operation
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            SHIFT_SLL:  o_data = {i_data[WIDTH-2:0], 1'b0};
            SHIFT_SRL:  o_data = {1'b0, i_data[WIDTH-1:1]};
            SHIFT_SRA:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            SHIFT_ROTR: o_data = {i_data[0], i_data[WIDTH-1:1]};
            default:    o_data = i_data;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// Multicycle shift unit: SLL / SRL / SRA / ROTR by a variable amount, one
// bit position per clock, with a start/busy/done handshake.
//
// Handshake: start is sampled on a rising edge whenever busy is low (IDLE or
// DONE). busy is high only while shifting; done is a one-cycle pulse during
// which out holds the result. out keeps that result until the next accepted
// operation reaches DONE.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   start     - request pulse, ignored while busy
//   op        - shift operation (shift_pkg SHIFT_* encoding)
//   shamt     - shift amount 0..WIDTH-1
//   in        - operand
//   busy      - high in SHIFT
//   done      - high for one cycle in DONE
//   out       - result register
//   dbg_state - current controller state for observation
module serial_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out,
    output logic [1:0]         dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_out;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_step;
    logic               w_accept;
    logic               w_last_step;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_data (r_work),
        .o_data (w_step)
    );

    // A new request is taken in any non-busy state (back-to-back from DONE).
    assign w_accept    = start && (r_state != ST_SHIFT);
    assign w_last_step = (r_state == ST_SHIFT) && (r_count == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_count == SHAMT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next_state = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath. out is only written on the edge that enters DONE, so a
    // later operation in flight never disturbs the previous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work  <= '0;
            r_out   <= '0;
            r_op    <= SHIFT_SLL;
            r_count <= '0;
        end else if (w_accept) begin
            r_work  <= in;
            r_op    <= op;
            r_count <= shamt;
            if (shamt == '0) begin
                r_out <= in;
            end
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_step;
            r_count <= r_count - SHAMT_W'(1);
            if (w_last_step) begin
                r_out <= w_step;
            end
        end
    end

    assign out       = r_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_shift_unit.sv
module tb_serial_shift_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [4:0]    shamt;
    logic [W-1:0]  din;
    logic          busy;
    logic          done;
    logic [W-1:0]  dout;
    logic [1:0]    dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .shamt     (shamt),
        .in        (din),
        .busy      (busy),
        .done      (done),
        .out       (dout),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [4:0]   shamt;
        logic [W-1:0] din;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    // Reference model: direct arithmetic on the whole word.
    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                               input logic [W-1:0] d);
        logic [W-1:0] r;
        case (o)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = W'($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (W - int'(s))));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: issues one operation from an idle state and returns in the done
    // cycle (or after the cycle budget runs out, with lat = -1).
    task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [W-1:0] d,
                          output logic [W-1:0] got, output int lat, output int bcnt,
                          output bit held);
        logic [W-1:0] prev;
        int c;
        prev = dout;
        held = 1'b1;
        bcnt = 0;
        lat  = -1;
        start = 1'b1; op = o; shamt = s; din = d;
        step();
        start = 1'b0;
        op    = 2'($urandom);
        shamt = 5'($urandom);
        din   = $urandom;
        c = 1;
        while (c <= 100) begin
            if (done) begin
                lat = c;
                break;
            end
            if (busy) bcnt++;
            if (dout !== prev) held = 1'b0;
            step();
            c++;
        end
        got = dout;
    endtask

    // Full scoreboarded operation: latency, busy length, result, hold.
    logic [W-1:0] exp_q[$];

    task automatic check_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                            input logic [W-1:0] d, input logic [W-1:0] exp_out);
        logic [W-1:0] got;
        logic [W-1:0] e;
        int lat, bcnt;
        bit held;
        exp_q.push_back(exp_out);
        run_op(o, s, d, got, lat, bcnt, held);
        e = exp_q.pop_front();
        chk({tag, " latency"}, W'(lat), W'(int'(s) + 1));
        chk({tag, " busy_cycles"}, W'(bcnt), W'(s));
        chk({tag, " out"}, got, e);
        chk({tag, " out_held_during_shift"}, W'(held), W'(1));
        step();
        chk({tag, " done_pulse_ends"}, W'(done), W'(0));
        chk({tag, " out_holds_after_done"}, dout, e);
    endtask

    initial begin
        logic [W-1:0] prev;
        int c, cnt;
        logic [1:0] ro;
        logic [4:0] rs;
        logic [W-1:0] rd;

        reset = 1'b1; start = 1'b0; op = '0; shamt = '0; din = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset busy", W'(busy), 0);
        chk("reset done", W'(done), 0);
        chk("reset out", dout, 0);
        chk("reset state", W'(dbg_state), 0);

        vecs[0] = '{2'b00, 5'd2,  32'h0000_0004, 32'h0000_0010};
        vecs[1] = '{2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F};
        vecs[2] = '{2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F};
        vecs[3] = '{2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002};
        vecs[4] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6] = '{2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        for (int i = 0; i < 8; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].din,
                     vecs[i].exp_out);
        end

        // start during SHIFT is ignored
        prev = dout;
        start = 1'b1; op = 2'b00; shamt = 5'd5; din = 32'h1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; op = 2'b01; shamt = 5'd0; din = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        chk("ignore_start busy", W'(busy), 1);
        chk("ignore_start out_prior", dout, prev);
        c = 3;
        while (!done && c < 50) begin
            step();
            c++;
        end
        chk("ignore_start latency", W'(c), 6);
        chk("ignore_start out", dout, 32'h20);
        step();

        // back-to-back start accepted in the DONE cycle
        begin
            logic [W-1:0] got;
            int lat, bcnt;
            bit held;
            run_op(2'b01, 5'd3, 32'h80, got, lat, bcnt, held);
            chk("b2b first out", got, 32'h10);
            start = 1'b1; op = 2'b00; shamt = 5'd1; din = 32'h1;
            step();
            start = 1'b0;
            chk("b2b shifting busy", W'(busy), 1);
            chk("b2b shifting done", W'(done), 0);
            chk("b2b out_held", dout, 32'h10);
            step();
            chk("b2b second done", W'(done), 1);
            chk("b2b second out", dout, 32'h2);
            step();
        end

        // reset in the middle of a shift
        start = 1'b1; op = 2'b01; shamt = 5'd10; din = 32'hFFFF_0000;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset busy", W'(busy), 0);
        chk("midreset done", W'(done), 0);
        chk("midreset out", dout, 0);
        chk("midreset state", W'(dbg_state), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) cnt++;
            step();
        end
        chk("midreset stray_done", W'(cnt), 0);
        check_op("after_reset", 2'b01, 5'd10, 32'hFFFF_0000, 32'h003F_FFC0);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            rd = $urandom;
            check_op($sformatf("rand%0d", i), ro, rs, rd, ref_shift(ro, rs, rd));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
